// File: rtl/timer_pkg.sv
// Shared definitions for the timer device: FSM encoding, register offsets, CTRL bit layout.
// Optional feature macro: TIMER_AUTO_RELOAD_EN (enables CTRL.MODE and the auto-reload path).
package timer_pkg;

   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_e;

   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_PRESET = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;

   localparam int unsigned CTRL_EN_BIT = 0;
   localparam int unsigned CTRL_IM_BIT = 3;

`ifdef TIMER_AUTO_RELOAD_EN
   localparam int unsigned CTRL_MODE_LSB = 1;
   localparam logic [1:0]  MODE_RELOAD   = 2'b01;
`endif

endpackage

// File: rtl/timer_dev.sv
// Programmable 32-bit down-counting timer with CTRL/PRESET/COUNT registers and IntReq.
// Optional feature macro: TIMER_AUTO_RELOAD_EN (MODE 01 periodic reload; otherwise one-shot only).
module timer_dev
   import timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h00007F00,
   parameter logic [31:0] RESET_PRESET = 32'h0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [1:0]        addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              IntReq
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] count_q, count_d;
   logic [DATA_W-1:0] preset_q, preset_d;
   logic              en_q, en_d;
   logic              im_q, im_d;
   logic              pending_q, pending_d;
   logic              reload;
   logic              set_pend;
   logic [1:0]        off;

   // Word offset relative to the window base, so a base not aligned to 16 bytes still decodes.
   assign off = addr - BASE_ADDR[3:2];

`ifdef TIMER_AUTO_RELOAD_EN
   logic [1:0] mode_q, mode_d;
   assign reload = (mode_q == MODE_RELOAD);
`else
   assign reload = 1'b0;
`endif

   // Next-state logic: FSM and counter first, then CPU writes so a CTRL write overrides a hardware EN clear.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      preset_d  = preset_q;
      en_d      = en_q;
      im_d      = im_q;
      pending_d = pending_q;
      set_pend  = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
      mode_d    = mode_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (en_q) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            count_d = preset_q;
            state_d = ST_CNT;
         end
         ST_CNT: begin
            if (!en_q) begin
               state_d = ST_IDLE;
            end else if (count_q > 32'd1) begin
               count_d = count_q - 32'd1;
            end else begin
               count_d   = '0;
               pending_d = 1'b1;
               set_pend  = 1'b1;
               state_d   = ST_INT;
            end
         end
         ST_INT: begin
            if (reload) begin
               pending_d = 1'b0;
               state_d   = ST_LOAD;
            end else begin
               en_d    = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (we) begin
         if (off == OFF_CTRL) begin
            en_d = din[CTRL_EN_BIT];
            im_d = din[CTRL_IM_BIT];
`ifdef TIMER_AUTO_RELOAD_EN
            mode_d = din[CTRL_MODE_LSB +: 2];
`endif
         end else if (off == OFF_PRESET) begin
            preset_d = din;
         end
         // A fresh expiry in the same cycle as the acknowledge is not lost.
         if (((off == OFF_CTRL) || (off == OFF_PRESET)) && !set_pend) pending_d = 1'b0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         preset_q  <= RESET_PRESET;
         en_q      <= 1'b0;
         im_q      <= 1'b0;
         pending_q <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
         mode_q    <= 2'b00;
`endif
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         preset_q  <= preset_d;
         en_q      <= en_d;
         im_q      <= im_d;
         pending_q <= pending_d;
`ifdef TIMER_AUTO_RELOAD_EN
         mode_q    <= mode_d;
`endif
      end
   end

   // Combinational read mux; reserved offset and unused CTRL bits read as zero.
   always_comb begin
      dout = '0;
      case (off)
         OFF_CTRL: begin
            dout[CTRL_EN_BIT] = en_q;
            dout[CTRL_IM_BIT] = im_q;
`ifdef TIMER_AUTO_RELOAD_EN
            dout[CTRL_MODE_LSB +: 2] = mode_q;
`endif
         end
         OFF_PRESET: dout = preset_q;
         OFF_COUNT:  dout = count_q;
         default:    dout = '0;
      endcase
   end

   assign IntReq = pending_q & im_q;

endmodule

// File: doc/timer_dev.md
# timer_dev

Programmable 32-bit down-counting timer on the microsystem device bus, occupying the device window starting at 0x00007F00. It generates `IntReq`, the interrupt request that the multi-cycle controller samples at instruction end before entering its exception state. The CPU programs the timer through word reads and writes (`lw`/`sw`) once the device-select decode routes the access here. A counter FSM loads, counts, and raises the interrupt either once or periodically.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h00007F00: device base; only `addr[3:2]` are decoded here.
- `RESET_PRESET`, default 32'h0: PRESET value after reset.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `we`, input, 1: write strobe; already qualified by device select.
- `addr`, input, 2: word offset. 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- `din`, input, 32: write data.
- `dout`, output, 32: combinational read data for `addr`. Reserved offset reads 0.
- `IntReq`, output, 1: interrupt request to the controller.

## Operation
- CTRL bits:
  - [0] EN: count enable.
  - [2:1] MODE: 00 = one-shot, 01 = auto-reload; 1x behaves as 00.
  - [3] IM: interrupt mask, 1 = allowed.
  - [31:4] read as 0; writes to them are ignored.
- PRESET is read/write. COUNT is read-only; writes to COUNT are ignored.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN = 1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if EN = 0, go to IDLE with COUNT held. Else if COUNT > 1, decrement. Else COUNT <= 0, set `pending`, go to INT.
  - INT, MODE 00: hardware clears EN; go to IDLE; `pending` stays set.
  - INT, MODE 01: go to LOAD; `pending` clears on leaving INT.
- `IntReq = pending & IM`.
- `pending` clears on any CPU write to CTRL or PRESET. This write is the ISR acknowledge.
- Simultaneous events:
  - A CPU write to CTRL in the same cycle as a hardware EN clear: the CPU write wins.
  - A PRESET write during CNT does not disturb COUNT; it takes effect at the next LOAD.
  - A CTRL write with EN = 0 during CNT or LOAD: FSM reaches IDLE on the next edge.
- PRESET = 0 behaves like PRESET = 1.
- Arithmetic: COUNT is unsigned 32-bit and never wraps below 0.

## Timing
- Reset values:
  - CTRL = 0, COUNT = 0, PRESET = RESET_PRESET.
  - State = IDLE, `pending` = 0, `IntReq` = 0.
  - `dout` reflects these registers combinationally.
- Reset mid-count aborts immediately; no interrupt is produced.
- Writes become visible on `dout` the cycle after the write edge.
- Enabling with PRESET = N (N ≥ 1) in either mode:
  - Edge E writes EN = 1.
  - COUNT = N after edge E+2.
  - `IntReq` rises after edge E+N+2.
- MODE 01 `IntReq` pulse:
  - High for exactly 1 cycle.
  - Period N+2 cycles.
- MODE 00 `IntReq`: held until acknowledged. The controller's EXL handles masking on the CPU side.

## Configuration
- `TIMER_AUTO_RELOAD_EN` defined:
  - MODE 01 auto-reload is supported as described above.
- `TIMER_AUTO_RELOAD_EN` undefined:
  - MODE bits read as 0 and are ignored on write.
  - Every expiry follows the one-shot path (INT -> IDLE, EN cleared).
  - The INT -> LOAD transition is not synthesized.

## Structure
- Shared package `timer_pkg` holds:
  - FSM state encoding (2-bit).
  - Register offsets CTRL = 0, PRESET = 1, COUNT = 2.
  - CTRL bit positions for EN, MODE, IM.
- No sub-module: the register file, FSM, and counter form one module (~150-200 lines).

## Test plan
- Reset, then read all three registers -> CTRL = 0, PRESET = 0, COUNT = 0, `IntReq` = 0.
- PRESET = 5; CTRL = 32'h9 (EN, IM, one-shot) -> `IntReq` rises 7 edges after the CTRL write and stays high; CTRL reads 8. A write of CTRL = 0 drops `IntReq` next cycle.
- PRESET = 3; CTRL = 32'hB (auto-reload) -> `IntReq` is a 1-cycle pulse every 5 cycles for at least 4 periods; EN stays 1.
- Same as the one-shot case but IM = 0 (CTRL = 32'h1) -> `IntReq` never asserts; COUNT = 0; EN cleared.
- PRESET = 100, enable, then write CTRL = 0 with COUNT = 60 -> COUNT freezes at 59 or 60 per the edge, state IDLE, no interrupt. Re-enable reloads 100.
- Assert `reset` low when COUNT = 2 -> after the edge, all registers are at reset values and no `IntReq` pulse appears. Build with `TIMER_AUTO_RELOAD_EN` undefined: CTRL = 32'hB behaves as one-shot and reads back 9.
